biquad8_zero_coeff_loader: RTL and testbench
============================================

Name: biquad8_zero_coeff_loader

Overview:
- Register-side driver for the coefficient load port of the biquad zero-FIR stages (the serial coeff_dat/coeff_wr/coeff_update interface into the HEAD/TAIL loadable-B DSP chain).
- Host software writes the b1 (z^-1) and b02 (z^0/z^-2) coefficients into shadow registers, then commits to a selected filter.
- The block sequences the two writes and the update strobe to that filter: first b1, then b02, then update.
- Also owns the per-filter bypass bits and a status/commit counter readable by software.

Parameters:
- NFILT, 2, number of zero-FIR instances driven (one coeff_wr/coeff_update bit each).
- SETTLE, 4, cycles after update strobe before the commit is reported done (covers the DSP B-register to P-out latency).
- CNT_BITS, 8, width of the completed-commit counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- reg_wr_i  in  1  register write strobe, one cycle.
- reg_rd_i  in  1  register read strobe, one cycle.
- reg_addr_i  in  2  register address: 0=B1, 1=B02, 2=COMMIT, 3=STATUS/BYPASS.
- reg_dat_i  in  32  write data.
- reg_dat_o  out  32  read data, valid one cycle after reg_rd_i.
- coeff_dat_o  out  18  coefficient (Q4.14) shared by all filters.
- coeff_wr_o  out  NFILT  per-filter coefficient write strobe.
- coeff_update_o  out  NFILT  per-filter coefficient update strobe.
- bypass_o  out  NFILT  per-filter bypass level.
- busy_o  out  1  sequence in progress (not IDLE).

Behaviour:
- Reset: all outputs 0, shadows 0, FSM IDLE, pending/overflow 0, counter 0.
- Writes: addr0 -> shadow_b1 = dat[17:0]; addr1 -> shadow_b02 = dat[17:0]; upper bits ignored.
- Writes: addr2 -> commit request, target = dat[$clog2(NFILT)-1:0]; target >= NFILT is dropped and sets overflow.
- Writes: addr3 -> bypass_o = dat[NFILT-1:0] (registered, 1-cycle latency); dat[31]=1 clears overflow (W1C).
- Commit capture: on acceptance, shadow_b1, shadow_b02 and target copy into working registers. Shadow writes during a sequence do not affect it.
- FSM states: IDLE, WR_B, WR_A, UPD, SETTLE.
- IDLE -> WR_B: on a commit, or on pending set (pending clears).
- WR_B (1 cycle): coeff_dat_o = b1; coeff_wr_o[target] = 1.
- WR_A (1 cycle): coeff_dat_o = b02; coeff_wr_o[target] = 1.
- UPD (1 cycle): coeff_update_o[target] = 1; coeff_wr_o = 0.
- SETTLE: counts SETTLE cycles, then -> IDLE and counter += 1 (wraps modulo 2^CNT_BITS).
- Latency: commit write in cycle N gives WR_B in N+1, WR_A in N+2, UPD in N+3, busy_o low in N+4+SETTLE.
- Strobes never overlap: only one filter's bit is ever high, and wr/update are never high in the same cycle.
- coeff_dat_o returns to 0 outside WR_B/WR_A.
- Commit while busy: if pending=0, snapshot shadows+target into the pending slot and set pending. Else drop the request and set overflow (sticky).
- Pending is serviced IDLE -> WR_B with no idle gap beyond the single IDLE cycle.
- Read data for addr0/1: sign-extended shadow.
- Read data for addr2: {counter, 0s}.
- Read data for addr3: bit0 busy, bit1 pending, bit2 overflow, bits[23:16] bypass, zero elsewhere.
- Simultaneous read and write to the same address: read returns the pre-write value.
- Reset mid-sequence: strobes drop immediately (async). No update is issued, so the filter's active coefficients stay as before; its B shadow chain may hold partial data, which the next full commit overwrites.

Decomposition:
- Shared package: register address constants, STATUS bit positions, coefficient width (18) and format constants, FSM state encoding.
- One natural sub-module: biquad8_coeff_seq (FSM + working/pending registers + strobe decode). The top module keeps the register file, bypass and readback.

Test Plan:
- Write B1=0x3C000, B02=0x04000, commit target 1 -> cycle+1 wr=2'b10 dat=0x3C000; +2 wr=2'b10 dat=0x04000; +3 update=2'b10; counter reads 1 after SETTLE.
- Commit during WR_A with new shadows -> second sequence follows immediately with new values; status pending=1 then 0; counter=2; overflow=0.
- Three commits back-to-back -> two sequences run, third dropped, overflow=1; write addr3 bit31 -> overflow=0.
- Assert rst_n low during WR_A -> coeff_wr_o, coeff_update_o, busy_o = 0 that cycle; no update pulse ever seen; next commit completes normally.
- Commit target 3 with NFILT=2 -> no strobes, overflow=1. Bypass write 0x3 -> bypass_o=2'b11 next cycle, readback bits[23:16]=0x03.
- Counter wrap: 256 commits -> counter reads 0; every strobe-bit check one-hot per cycle throughout.

Source files
------------

// File: rtl/biquad8_zero_coeff_loader_pkg.sv
// Shared definitions for the biquad zero-FIR coefficient loader: register map,
// status bit positions, coefficient format and sequencer state encoding.
package biquad8_zero_coeff_loader_pkg;

    localparam int COEFF_W     = 18;   // Q4.14
    localparam int COEFF_FRAC  = 14;
    localparam int TGT_FIELD_W = 8;    // commit target field, wide enough to detect out-of-range targets

    localparam logic [1:0] ADDR_B1     = 2'd0;
    localparam logic [1:0] ADDR_B02    = 2'd1;
    localparam logic [1:0] ADDR_COMMIT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_PEND    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_BYP_LSB = 16;
    localparam int STAT_W1C     = 31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_B   = 3'd1,
        ST_WR_A   = 3'd2,
        ST_UPD    = 3'd3,
        ST_SETTLE = 3'd4
    } seq_state_e;

    function automatic logic [31:0] sext_coeff(input logic [COEFF_W-1:0] c);
        return {{(32-COEFF_W){c[COEFF_W-1]}}, c};
    endfunction

endpackage

// File: rtl/biquad8_coeff_seq.sv
// Commit sequencer: captures a commit into working (or pending) registers and
// drives the b1 write, b02 write and update strobes to one filter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no sequence; starts pending commit first, else a new one
// ST_WR_B   | coeff_dat_o = b1, coeff_wr_o[target] high
// ST_WR_A   | coeff_dat_o = b02, coeff_wr_o[target] high
// ST_UPD    | coeff_update_o[target] high
// ST_SETTLE | down-counts SETTLE cycles, then reports done
module biquad8_coeff_seq
    import biquad8_zero_coeff_loader_pkg::*;
#(
    parameter int NFILT  = 2,
    parameter int SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   commit_i,
    input  logic [TGT_FIELD_W-1:0] commit_tgt_i,
    input  logic [COEFF_W-1:0]     b1_i,
    input  logic [COEFF_W-1:0]     b02_i,
    output logic [COEFF_W-1:0]     coeff_dat_o,
    output logic [NFILT-1:0]       coeff_wr_o,
    output logic [NFILT-1:0]       coeff_update_o,
    output logic                   busy_o,
    output logic                   pending_o,
    output logic                   drop_o,
    output logic                   done_o
);

    localparam int TW = (NFILT > 1) ? $clog2(NFILT) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TGT_FIELD_W-1:0] NFILT_LIM = TGT_FIELD_W'(NFILT);

    seq_state_e         state_q, state_d;
    logic [COEFF_W-1:0] wb1_q, wb1_d, wb02_q, wb02_d;
    logic [COEFF_W-1:0] pb1_q, pb1_d, pb02_q, pb02_d;
    logic [TW-1:0]      wtgt_q, wtgt_d, ptgt_q, ptgt_d;
    logic               pend_q, pend_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic               tgt_ok;
    logic [NFILT-1:0]   tgt_hot;

    assign tgt_ok  = commit_i && (commit_tgt_i < NFILT_LIM);
    assign tgt_hot = NFILT'(1) << wtgt_q;

    always_comb begin
        state_d  = state_q;
        wb1_d    = wb1_q;
        wb02_d   = wb02_q;
        wtgt_d   = wtgt_q;
        pb1_d    = pb1_q;
        pb02_d   = pb02_q;
        ptgt_d   = ptgt_q;
        pend_d   = pend_q;
        settle_d = settle_q;
        drop_o   = commit_i && !tgt_ok;
        done_o   = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pend_q) begin
                // Older pending commit goes first; a new one refills the freed slot.
                state_d = ST_WR_B;
                wb1_d   = pb1_q;
                wb02_d  = pb02_q;
                wtgt_d  = ptgt_q;
                pend_d  = 1'b0;
                if (tgt_ok) begin
                    pb1_d  = b1_i;
                    pb02_d = b02_i;
                    ptgt_d = commit_tgt_i[TW-1:0];
                    pend_d = 1'b1;
                end
            end else if (tgt_ok) begin
                state_d = ST_WR_B;
                wb1_d   = b1_i;
                wb02_d  = b02_i;
                wtgt_d  = commit_tgt_i[TW-1:0];
            end
        end else if (tgt_ok) begin
            if (!pend_q) begin
                pb1_d  = b1_i;
                pb02_d = b02_i;
                ptgt_d = commit_tgt_i[TW-1:0];
                pend_d = 1'b1;
            end else begin
                drop_o = 1'b1;
            end
        end

        unique case (state_q)
            ST_WR_B: state_d = ST_WR_A;
            ST_WR_A: state_d = ST_UPD;
            ST_UPD: begin
                state_d  = ST_SETTLE;
                settle_d = SW'(SETTLE - 1);
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_IDLE;
                    done_o  = 1'b1;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wb1_q    <= '0;
            wb02_q   <= '0;
            wtgt_q   <= '0;
            pb1_q    <= '0;
            pb02_q   <= '0;
            ptgt_q   <= '0;
            pend_q   <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            wb1_q    <= wb1_d;
            wb02_q   <= wb02_d;
            wtgt_q   <= wtgt_d;
            pb1_q    <= pb1_d;
            pb02_q   <= pb02_d;
            ptgt_q   <= ptgt_d;
            pend_q   <= pend_d;
            settle_q <= settle_d;
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    always_comb begin
        coeff_dat_o    = '0;
        coeff_wr_o     = '0;
        coeff_update_o = '0;
        unique case (state_q)
            ST_WR_B: begin
                coeff_dat_o = wb1_q;
                coeff_wr_o  = tgt_hot;
            end
            ST_WR_A: begin
                coeff_dat_o = wb02_q;
                coeff_wr_o  = tgt_hot;
            end
            ST_UPD:  coeff_update_o = tgt_hot;
            default: ;
        endcase
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign pending_o = pend_q;

endmodule

// File: rtl/biquad8_zero_coeff_loader.sv
// Register front end for the zero-FIR coefficient loader: shadow coefficients,
// commit decode, bypass bits, overflow flag, commit counter and readback.
module biquad8_zero_coeff_loader
    import biquad8_zero_coeff_loader_pkg::*;
#(
    parameter int NFILT    = 2,
    parameter int SETTLE   = 4,
    parameter int CNT_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reg_wr_i,
    input  logic               reg_rd_i,
    input  logic [1:0]         reg_addr_i,
    input  logic [31:0]        reg_dat_i,
    output logic [31:0]        reg_dat_o,
    output logic [COEFF_W-1:0] coeff_dat_o,
    output logic [NFILT-1:0]   coeff_wr_o,
    output logic [NFILT-1:0]   coeff_update_o,
    output logic [NFILT-1:0]   bypass_o,
    output logic               busy_o
);

    logic [COEFF_W-1:0]  b1_q, b1_d, b02_q, b02_d;
    logic [NFILT-1:0]    byp_q, byp_d;
    logic                ovf_q, ovf_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]         rdat_q, rdat_d;
    logic [31:0]         status_w;
    logic                commit_w, pend_w, drop_w, done_w;
    logic                unused_dat;

    assign commit_w   = reg_wr_i && (reg_addr_i == ADDR_COMMIT);
    assign unused_dat = ^reg_dat_i[30:COEFF_W];

    biquad8_coeff_seq #(
        .NFILT  (NFILT),
        .SETTLE (SETTLE)
    ) u_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .commit_i       (commit_w),
        .commit_tgt_i   (reg_dat_i[TGT_FIELD_W-1:0]),
        .b1_i           (b1_q),
        .b02_i          (b02_q),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_update_o (coeff_update_o),
        .busy_o         (busy_o),
        .pending_o      (pend_w),
        .drop_o         (drop_w),
        .done_o         (done_w)
    );

    always_comb begin
        status_w                             = '0;
        status_w[STAT_BUSY]                  = busy_o;
        status_w[STAT_PEND]                  = pend_w;
        status_w[STAT_OVF]                   = ovf_q;
        status_w[STAT_BYP_LSB +: NFILT]      = byp_q;
    end

    always_comb begin
        b1_d   = b1_q;
        b02_d  = b02_q;
        byp_d  = byp_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        rdat_d = '0;

        if (reg_wr_i) begin
            unique case (reg_addr_i)
                ADDR_B1:     b1_d  = reg_dat_i[COEFF_W-1:0];
                ADDR_B02:    b02_d = reg_dat_i[COEFF_W-1:0];
                ADDR_COMMIT: ;
                ADDR_STATUS: begin
                    byp_d = reg_dat_i[NFILT-1:0];
                    if (reg_dat_i[STAT_W1C]) ovf_d = 1'b0;
                end
            endcase
        end
        if (drop_w) ovf_d = 1'b1;
        if (done_w) cnt_d = cnt_q + CNT_BITS'(1);

        // Readback samples current register values, so a same-cycle write is not yet visible.
        if (reg_rd_i) begin
            unique case (reg_addr_i)
                ADDR_B1:     rdat_d = sext_coeff(b1_q);
                ADDR_B02:    rdat_d = sext_coeff(b02_q);
                ADDR_COMMIT: rdat_d = {cnt_q, {(32-CNT_BITS){1'b0}}};
                ADDR_STATUS: rdat_d = status_w;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_q   <= '0;
            b02_q  <= '0;
            byp_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            rdat_q <= '0;
        end else begin
            b1_q   <= b1_d;
            b02_q  <= b02_d;
            byp_q  <= byp_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            rdat_q <= rdat_d;
        end
    end

    assign bypass_o  = byp_q;
    assign reg_dat_o = rdat_q;

endmodule

// File: tb/tb_biquad8_zero_coeff_loader.sv
// Directed bench for the zero-FIR coefficient loader: sequencing, pending and
// overflow handling, async reset mid-sequence, bypass and counter wrap.
module tb_biquad8_zero_coeff_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [31:0] reg_wdat = 32'd0;
    logic [31:0] reg_rdat;
    logic [17:0] coeff_dat;
    logic [1:0]  coeff_wr;
    logic [1:0]  coeff_upd;
    logic [1:0]  bypass;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int viol = 0;
    int upd0 = 0;
    int upd1 = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    biquad8_zero_coeff_loader #(.NFILT(2), .SETTLE(4), .CNT_BITS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_wr_i       (reg_wr),
        .reg_rd_i       (reg_rd),
        .reg_addr_i     (reg_addr),
        .reg_dat_i      (reg_wdat),
        .reg_dat_o      (reg_rdat),
        .coeff_dat_o    (coeff_dat),
        .coeff_wr_o     (coeff_wr),
        .coeff_update_o (coeff_upd),
        .bypass_o       (bypass),
        .busy_o         (busy)
    );

    // Strobe monitor: one-hot, wr/update exclusive, data zero when not writing.
    always @(posedge clk) begin
        if (rst_n) begin
            if ($countones(coeff_wr) > 1 || $countones(coeff_upd) > 1 ||
                (coeff_wr != 2'b00 && coeff_upd != 2'b00) ||
                (coeff_wr == 2'b00 && coeff_dat != 18'h0))
                viol++;
            if (coeff_upd[0]) upd0++;
            if (coeff_upd[1]) upd1++;
        end
    end

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdat = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_rd = 1'b0;
        d = reg_rdat;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({coeff_wr, coeff_upd, bypass, busy, coeff_dat, reg_rdat} !== '0) begin
            failures++;
            $display("FAIL reset_outputs wr=%b upd=%b byp=%b busy=%b dat=%h rdat=%h expected all 0",
                     coeff_wr, coeff_upd, bypass, busy, coeff_dat, reg_rdat);
        end
        rst_n = 1'b1;
        step(1);
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=00000000", rd); end
        reg_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_b1 got=%h exp=00000000", rd); end
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_counter got=%h exp=00000000", rd); end
    endtask

    task automatic test_basic();
        reg_write(2'd0, 32'h0003_C000);
        reg_write(2'd1, 32'h0000_4000);
        reg_write(2'd2, 32'd1);
        checks++;
        if (coeff_wr !== 2'b10 || coeff_dat !== 18'h3C000 || busy !== 1'b1) begin
            failures++; $display("FAIL basic_wr_b wr=%b dat=%h busy=%b exp wr=10 dat=3c000 busy=1", coeff_wr, coeff_dat, busy);
        end
        step(1);
        checks++;
        if (coeff_wr !== 2'b10 || coeff_dat !== 18'h04000) begin
            failures++; $display("FAIL basic_wr_a wr=%b dat=%h exp wr=10 dat=04000", coeff_wr, coeff_dat);
        end
        step(1);
        checks++;
        if (coeff_upd !== 2'b10 || coeff_wr !== 2'b00 || coeff_dat !== 18'h0) begin
            failures++; $display("FAIL basic_upd upd=%b wr=%b dat=%h exp upd=10 wr=00 dat=0", coeff_upd, coeff_wr, coeff_dat);
        end
        step(4);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_settle got=%b exp=1", busy); end
        step(1);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
        reg_read(2'd0, rd);
        checks++;
        if (rd !== 32'hFFFF_C000) begin failures++; $display("FAIL basic_b1_sext got=%h exp=ffffc000", rd); end
        reg_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_4000) begin failures++; $display("FAIL basic_b02_read got=%h exp=00004000", rd); end
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0100_0000) begin failures++; $display("FAIL basic_counter got=%h exp=01000000", rd); end
    endtask

    task automatic test_pending();
        reg_write(2'd0, 32'h0000_0100);
        reg_write(2'd1, 32'h0000_0200);
        reg_write(2'd2, 32'd0);
        checks++;
        if (coeff_wr !== 2'b01 || coeff_dat !== 18'h00100) begin
            failures++; $display("FAIL pend_first_wr_b wr=%b dat=%h exp wr=01 dat=00100", coeff_wr, coeff_dat);
        end
        reg_write(2'd1, 32'h0000_0300);
        checks++;
        if (coeff_wr !== 2'b01 || coeff_dat !== 18'h00200) begin
            failures++; $display("FAIL pend_first_wr_a wr=%b dat=%h exp wr=01 dat=00200", coeff_wr, coeff_dat);
        end
        reg_write(2'd2, 32'd1);
        checks++;
        if (coeff_upd !== 2'b01) begin failures++; $display("FAIL pend_first_upd got=%b exp=01", coeff_upd); end
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin failures++; $display("FAIL pend_status_set got=%h exp=00000003", rd); end
        step(4);
        checks++;
        if (busy !== 1'b0 || coeff_wr !== 2'b00) begin
            failures++; $display("FAIL pend_idle_gap busy=%b wr=%b exp busy=0 wr=00", busy, coeff_wr);
        end
        step(1);
        checks++;
        if (coeff_wr !== 2'b10 || coeff_dat !== 18'h00100) begin
            failures++; $display("FAIL pend_second_wr_b wr=%b dat=%h exp wr=10 dat=00100", coeff_wr, coeff_dat);
        end
        step(1);
        checks++;
        if (coeff_wr !== 2'b10 || coeff_dat !== 18'h00300) begin
            failures++; $display("FAIL pend_second_wr_a wr=%b dat=%h exp wr=10 dat=00300", coeff_wr, coeff_dat);
        end
        step(1);
        checks++;
        if (coeff_upd !== 2'b10) begin failures++; $display("FAIL pend_second_upd got=%b exp=10", coeff_upd); end
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin failures++; $display("FAIL pend_status_clear got=%h exp=00000001", rd); end
        step(4);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL pend_done busy=%b exp=0", busy); end
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0300_0000) begin failures++; $display("FAIL pend_counter got=%h exp=03000000", rd); end
    endtask

    task automatic test_back_to_back();
        int u0, u1;
        u0 = upd0; u1 = upd1;
        reg_write(2'd2, 32'd0);
        reg_write(2'd2, 32'd1);
        reg_write(2'd2, 32'd0);
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0000_0007) begin failures++; $display("FAIL b2b_status got=%h exp=00000007", rd); end
        step(13);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", busy); end
        step(10);
        checks++;
        if (upd0 - u0 != 1 || upd1 - u1 != 1) begin
            failures++; $display("FAIL b2b_updates f0=%0d f1=%0d exp f0=1 f1=1", upd0 - u0, upd1 - u1);
        end
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0500_0000) begin failures++; $display("FAIL b2b_counter got=%h exp=05000000", rd); end
        reg_write(2'd3, 32'h8000_0000);
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0000_0000) begin failures++; $display("FAIL b2b_ovf_clear got=%h exp=00000000", rd); end
    endtask

    task automatic test_reset_mid();
        int u1;
        u1 = upd1;
        reg_write(2'd2, 32'd1);
        step(1);
        checks++;
        if (coeff_wr !== 2'b10) begin failures++; $display("FAIL rmid_in_wr_a got=%b exp=10", coeff_wr); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (coeff_wr !== 2'b00 || coeff_upd !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL rmid_async wr=%b upd=%b busy=%b exp all 0", coeff_wr, coeff_upd, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(8);
        checks++;
        if (upd1 != u1) begin failures++; $display("FAIL rmid_no_update pulses=%0d exp=0", upd1 - u1); end
        reg_write(2'd0, 32'h0001_ABCD);
        reg_write(2'd1, 32'h0002_0001);
        reg_write(2'd2, 32'd0);
        checks++;
        if (coeff_wr !== 2'b01 || coeff_dat !== 18'h1ABCD) begin
            failures++; $display("FAIL rmid_wr_b wr=%b dat=%h exp wr=01 dat=1abcd", coeff_wr, coeff_dat);
        end
        step(1);
        checks++;
        if (coeff_wr !== 2'b01 || coeff_dat !== 18'h20001) begin
            failures++; $display("FAIL rmid_wr_a wr=%b dat=%h exp wr=01 dat=20001", coeff_wr, coeff_dat);
        end
        step(1);
        checks++;
        if (coeff_upd !== 2'b01) begin failures++; $display("FAIL rmid_upd got=%b exp=01", coeff_upd); end
        step(5);
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0100_0000) begin failures++; $display("FAIL rmid_counter got=%h exp=01000000", rd); end
    endtask

    task automatic test_bad_target_bypass();
        reg_write(2'd2, 32'd3);
        checks++;
        if (coeff_wr !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL bad_tgt_nostart wr=%b busy=%b exp wr=00 busy=0", coeff_wr, busy);
        end
        step(2);
        checks++;
        if (coeff_upd !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL bad_tgt_idle upd=%b busy=%b exp upd=00 busy=0", coeff_upd, busy);
        end
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin failures++; $display("FAIL bad_tgt_ovf got=%h exp=00000004", rd); end
        reg_write(2'd3, 32'h8000_0000);
        reg_write(2'd3, 32'h0000_0003);
        checks++;
        if (bypass !== 2'b11) begin failures++; $display("FAIL bypass_out got=%b exp=11", bypass); end
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0003_0000) begin failures++; $display("FAIL bypass_read got=%h exp=00030000", rd); end
        reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 2'd0; reg_wdat = 32'h0000_0155;
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b0;
        checks++;
        if (reg_rdat !== 32'h0001_ABCD) begin failures++; $display("FAIL rw_same_addr got=%h exp=0001abcd", reg_rdat); end
        reg_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0000_0155) begin failures++; $display("FAIL rw_after_write got=%h exp=00000155", rd); end
    endtask

    task automatic test_counter_wrap();
        int u;
        bit timed_out;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        u = upd0 + upd1;
        timed_out = 1'b0;
        for (int i = 0; i < 256 && !timed_out; i++) begin
            int n;
            reg_write(2'd2, 32'(i % 2));
            n = 0;
            while (busy && n < 30) begin
                step(1);
                n++;
            end
            if (busy) begin
                timed_out = 1'b1;
                checks++; failures++;
                $display("FAIL wrap_timeout commit=%0d busy=%b exp=0 within 30 cycles", i, busy);
            end
            if (i == 254) begin
                reg_read(2'd2, rd);
                checks++;
                if (rd !== 32'hFF00_0000) begin failures++; $display("FAIL wrap_counter_255 got=%h exp=ff000000", rd); end
            end
        end
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0000_0000) begin failures++; $display("FAIL wrap_counter_0 got=%h exp=00000000", rd); end
        checks++;
        if (upd0 + upd1 - u != 256) begin failures++; $display("FAIL wrap_updates got=%0d exp=256", upd0 + upd1 - u); end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL strobe_onehot violations=%0d exp=0", viol); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        test_bad_target_bypass();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
